serial_adder: RTL and testbench

- Parametrised, multi-cycle successor to the single-bit full adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, through one DIGIT-bit ripple stage and operand shift registers.
- Uses a start/busy/done handshake and reports carry-out and signed overflow.
- Arithmetic leaf for datapaths that trade latency for area.

---
 rtl/serial_adder_if.sv | 27 ++
 rtl/serial_adder.sv | 139 +++++++++++++
 tb/tb_serial_adder.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: start request, operands and registered results.
// Latency: none (wires only).
// Backpressure: start is ignored by the slave while busy is high.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output start, a, b, c_in, sub,
    input  busy, done, sum, c_out, overflow
  );

  modport slave (
    input  start, a, b, c_in, sub,
    output busy, done, sum, c_out, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial add/subtract: DIGIT bits per cycle through one ripple stage, with carry-out and signed overflow.
// Latency: start accepted at edge t0, done pulses in the cycle after edge t0+WIDTH/DIGIT.
// Backpressure: start is only sampled while busy=0 (IDLE or the DONE cycle); otherwise it is dropped, never queued.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic          clk,
  input logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   sum_q;
  logic               c_out_q;
  logic               ovf_q;

  logic               accept;
  logic               last_step;
  logic [DIGIT-1:0]   dig_sum;
  logic               dig_cout;
  logic               dig_cmsb;
  logic [WIDTH-1:0]   res_next;

  // One DIGIT-wide ripple stage; also returns the carry into its top bit,
  // which on the final step is the carry into the operand MSB.
  function automatic logic [DIGIT+1:0] digit_add(input logic [DIGIT-1:0] x,
                                                 input logic [DIGIT-1:0] y,
                                                 input logic             cin);
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] s;
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    return {c[DIGIT-1], c[DIGIT], s};
  endfunction

  assign accept    = bus.start && (state_q != RUN);
  assign last_step = (state_q == RUN) && (cnt_q == CNT_W'(STEPS - 1));

  // Current digit of the sum from the low bits of the shifting operands.
  always_comb begin
    {dig_cmsb, dig_cout, dig_sum} = digit_add(a_q[DIGIT-1:0], b_q[DIGIT-1:0], carry_q);
  end

  // Result digits enter from the MSB end; with a single step there is nothing to accumulate.
  generate
    if (WIDTH > DIGIT) begin : g_acc
      logic [WIDTH-DIGIT-1:0] acc_q;

      assign res_next = {dig_sum, acc_q};

      // Partial result accumulator, only advanced while running.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_q <= '0;
        end else if (state_q == RUN) begin
          acc_q <= res_next[WIDTH-1:DIGIT];
        end
      end
    end else begin : g_noacc
      assign res_next = dig_sum;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: DONE lasts one cycle and may chain straight into RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, per-step shift/carry update, and result load on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + ~borrow_in, so invert B and the incoming carry here.
      a_q     <= bus.a;
      b_q     <= bus.sub ? ~bus.b : bus.b;
      carry_q <= bus.c_in ^ bus.sub;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      carry_q <= dig_cout;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_step) begin
        sum_q   <= res_next;
        c_out_q <= dig_cout;
        ovf_q   <= dig_cout ^ dig_cmsb;
      end
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.sum      = sum_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder in three shapes (1/1, 8/1, 8/4) with a queue scoreboard.
// Latency: expected done cycle is recorded per transaction and checked by the monitor.
// Backpressure: the driver waits for busy=0 before asserting start.
module tb_serial_adder;

  typedef struct {
    int sum;
    int c;
    int v;
    int cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  exp_t q1[$];
  exp_t q8[$];
  exp_t q4[$];

  serial_adder_if #(.WIDTH(1)) if1 ();
  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(8)) if4 ();

  serial_adder #(.WIDTH(1), .DIGIT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "global timeout");
  end

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int width_of(input int id);
    return (id == 1) ? 1 : 8;
  endfunction

  function automatic int steps_of(input int id);
    return (id == 1) ? 1 : (id == 8) ? 8 : 2;
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input int id, input int a, input int b, input int c, input int s);
    exp_t e;
    int m, r, sa, sb, sr;
    m  = 1 << width_of(id);
    r  = s ? (a - b - c) : (a + b + c);
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    sr = s ? (sa - sb - c) : (sa + sb + c);
    e.sum = ((r % m) + m) % m;
    e.c   = s ? int'(a >= b + c) : int'(r >= m);
    e.v   = int'(sr < -(m / 2) || sr > (m / 2 - 1));
    e.cyc = 0;
    return e;
  endfunction

  function automatic logic busy_of(input int id);
    case (id)
      1:       return if1.busy;
      8:       return if8.busy;
      default: return if4.busy;
    endcase
  endfunction

  function automatic int qsize(input int id);
    case (id)
      1:       return q1.size();
      8:       return q8.size();
      default: return q4.size();
    endcase
  endfunction

  function automatic exp_t qpop(input int id);
    case (id)
      1:       return q1.pop_front();
      8:       return q8.pop_front();
      default: return q4.pop_front();
    endcase
  endfunction

  function automatic void qpush(input int id, input exp_t e);
    case (id)
      1:       q1.push_back(e);
      8:       q8.push_back(e);
      default: q4.push_back(e);
    endcase
  endfunction

  task automatic drive(input int id, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic s, input logic st);
    case (id)
      1: begin if1.a = a[0]; if1.b = b[0]; if1.c_in = c; if1.sub = s; if1.start = st; end
      8: begin if8.a = a;    if8.b = b;    if8.c_in = c; if8.sub = s; if8.start = st; end
      default: begin if4.a = a; if4.b = b; if4.c_in = c; if4.sub = s; if4.start = st; end
    endcase
  endtask

  // Called just after a falling edge; returns the index of the accepting rising edge.
  task automatic issue(input int id, input int a, input int b, input int c, input int s,
                       output int t0);
    int g;
    g = 0;
    while (busy_of(id) && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_wait_%0d: busy still 1 after 50 cycles, required 0", id);
    end
    drive(id, a[7:0], b[7:0], c[0], s[0], 1'b1);
    @(negedge clk);
    t0 = cyc;
    // Scramble the inputs after capture; they must have no effect.
    drive(id, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic model_issue(input int id, input int a, input int b, input int c, input int s);
    int   t0;
    exp_t e;
    issue(id, a, b, c, s, t0);
    e     = model(id, a, b, c, s);
    e.cyc = t0 + steps_of(id);
    qpush(id, e);
  endtask

  task automatic const_issue(input int id, input int a, input int b, input int c, input int s,
                             input int es, input int ec, input int ev);
    int t0;
    issue(id, a, b, c, s, t0);
    qpush(id, '{es, ec, ev, t0 + steps_of(id)});
  endtask

  task automatic mon(input int id, input int sum, input int c, input int v,
                     input logic done, input logic busy);
    exp_t e;
    if (!done) return;
    if (qsize(id) == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL spurious_done_%0d: got done=1 at cycle %0d, required no pulse", id, cyc);
      return;
    end
    e = qpop(id);
    chk($sformatf("sum_%0d", id), sum, e.sum);
    chk($sformatf("c_out_%0d", id), c, e.c);
    chk($sformatf("overflow_%0d", id), v, e.v);
    chk($sformatf("done_cycle_%0d", id), cyc, e.cyc);
    chk($sformatf("busy_in_done_%0d", id), int'(busy), 0);
  endtask

  // Monitor: consumes expectations whenever a DUT pulses done.
  always @(negedge clk) begin
    mon(1, int'(if1.sum), int'(if1.c_out), int'(if1.overflow), if1.done, if1.busy);
    mon(8, int'(if8.sum), int'(if8.c_out), int'(if8.overflow), if8.done, if8.busy);
    mon(4, int'(if4.sum), int'(if4.c_out), int'(if4.overflow), if4.done, if4.busy);
  end

  task automatic drain();
    int g;
    g = 0;
    while ((q1.size() + q8.size() + q4.size()) != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d results still outstanding, required 0",
               q1.size() + q8.size() + q4.size());
      q1.delete();
      q8.delete();
      q4.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    drive(1, 8'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    drive(8, 8'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    drive(4, 8'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    chk("rst_busy_8", int'(if8.busy), 0);
    chk("rst_done_8", int'(if8.done), 0);
    chk("rst_sum_8", int'(if8.sum), 0);
    chk("rst_c_out_8", int'(if8.c_out), 0);
    chk("rst_overflow_8", int'(if8.overflow), 0);
    chk("rst_busy_1", int'(if1.busy), 0);
    chk("rst_sum_4", int'(if4.sum), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full-adder truth table, back-to-back.
    for (int i = 0; i < 8; i++) begin
      int a, b, c, co;
      a  = (i >> 2) & 1;
      b  = (i >> 1) & 1;
      c  = i & 1;
      co = (a & b) | (c & (a ^ b));
      const_issue(1, a, b, c, 0, a ^ b ^ c, co, c ^ co);
    end

    // Directed 8-bit add/sub, then the 4-bit digit case.
    const_issue(8, 8'h5A, 8'h3C, 0, 0, 8'h96, 0, 1);
    const_issue(8, 8'hFF, 8'h01, 1, 0, 8'h01, 1, 0);
    const_issue(8, 8'h10, 8'h20, 0, 1, 8'hF0, 0, 0);
    const_issue(8, 8'h80, 8'h01, 0, 1, 8'h7F, 1, 1);
    const_issue(4, 8'h5A, 8'h3C, 0, 0, 8'h96, 0, 1);
    drain();

    // start pulsed mid-RUN with other operands must be ignored.
    const_issue(8, 8'hC0, 8'hA0, 0, 0, 8'h60, 1, 1);
    repeat (2) @(negedge clk);
    drive(8, 8'h01, 8'h01, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    drive(8, 8'h01, 8'h01, 1'b1, 1'b1, 1'b0);
    drain();

    // Reset at step 4: outputs clear at once and the aborted op never completes.
    issue(8, 8'h12, 8'h34, 0, 0, t);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(if8.busy), 0);
    chk("midrst_done", int'(if8.done), 0);
    chk("midrst_sum", int'(if8.sum), 0);
    chk("midrst_c_out", int'(if8.c_out), 0);
    chk("midrst_overflow", int'(if8.overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    const_issue(8, 8'h12, 8'h34, 0, 0, 8'h46, 0, 0);
    drain();

    // Randomised traffic on all three instances concurrently.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          model_issue(4, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 150; i++) begin
          model_issue(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 100; i++) begin
          model_issue(1, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      end
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
